// File: rtl/collision_pkg.sv
// Shared definitions for the toolpath collision interface (feeder and detector).
package collision_pkg;

    localparam int COORD_W           = 8;
    localparam int SEG_W             = 6 * COORD_W;
    // Line-memory capacity of the detector; the feeder stops after this many segments.
    localparam int MAX_LINES_DEFAULT = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] z1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COORD_W-1:0] z2;
    } segment_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } tx_state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous FIFO with wrap-around pointers; one extra pointer bit tells full from empty.
module seg_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointer update; a reset discards any stored segments.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/segment_feeder.sv
// Turns a vertex stream into line segments and strobes them into the collision detector.
module segment_feeder
    import collision_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_LINES  = MAX_LINES_DEFAULT,
    parameter int GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic               pt_new_path,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic [COORD_W-1:0] pt_z,
    output logic               in_val,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] z1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y2,
    output logic [COORD_W-1:0] z2,
    output logic [7:0]         line_count,
    output logic [7:0]         drop_count,
    output logic               busy,
    output logic               done
);

    localparam int            GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]    LC_LAST  = 8'(MAX_LINES - 1);

    logic [COORD_W-1:0] prev_x_q, prev_y_q, prev_z_q;
    logic               have_prev_q;
    logic               accept, formed, degen, push, drop_evt, pop;
    logic               fifo_full, fifo_empty;
    logic [SEG_W-1:0]   fifo_rdata;
    segment_t           cur_seg, out_q;
    tx_state_t          state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               in_val_q, done_q;
    logic [7:0]         line_count_q, drop_count_q;

    assign pt_ready = !fifo_full && !done_q;
    assign accept   = pt_valid && pt_ready;
    assign cur_seg  = {prev_x_q, prev_y_q, prev_z_q, pt_x, pt_y, pt_z};
    assign degen    = (prev_x_q == pt_x) && (prev_y_q == pt_y) && (prev_z_q == pt_z);
    assign formed   = accept && have_prev_q && !pt_new_path;
    assign push     = formed && !degen;
    assign drop_evt = formed && degen;

    seg_fifo #(
        .WIDTH (SEG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (cur_seg),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Segment former: every accepted vertex becomes the start point of the next segment.
    always_ff @(posedge clk) begin
        if (reset) begin
            have_prev_q <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            prev_z_q    <= '0;
        end else if (accept) begin
            have_prev_q <= 1'b1;
            prev_x_q    <= pt_x;
            prev_y_q    <= pt_y;
            prev_z_q    <= pt_z;
        end
    end

    // Transmit FSM next state: pop in IDLE, then setup, one-cycle strobe, and a low gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !done_q) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM state and registered strobe, so in_val is a clean flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            in_val_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            in_val_q <= (state_d == ST_STROBE);
        end
    end

    // Output segment registers change only on a pop, so data is stable across the strobe.
    always_ff @(posedge clk) begin
        if (reset)    out_q <= '0;
        else if (pop) out_q <= segment_t'(fifo_rdata);
    end

    // Sent/dropped counters and the sticky done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_count_q <= '0;
            drop_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            if (state_q == ST_STROBE) begin
                line_count_q <= line_count_q + 1'b1;
                if (line_count_q == LC_LAST) done_q <= 1'b1;
            end
            if (drop_evt && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 1'b1;
        end
    end

    assign in_val     = in_val_q;
    assign x1         = out_q.x1;
    assign y1         = out_q.y1;
    assign z1         = out_q.z1;
    assign x2         = out_q.x2;
    assign y2         = out_q.y2;
    assign z2         = out_q.z2;
    assign line_count = line_count_q;
    assign drop_count = drop_count_q;
    assign done       = done_q;
    assign busy       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_segment_feeder.sv
// Directed bench for segment_feeder with hand-computed expected segments and counters.
module tb_segment_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pt_valid = 1'b0;
    logic       pt_ready;
    logic       pt_new_path = 1'b0;
    logic [7:0] pt_x = '0, pt_y = '0, pt_z = '0;
    logic       in_val;
    logic [7:0] x1, y1, z1, x2, y2, z2;
    logic [7:0] line_count, drop_count;
    logic       busy, done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    segment_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_new_path (pt_new_path),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_z        (pt_z),
        .in_val      (in_val),
        .x1          (x1),
        .y1          (y1),
        .z1          (z1),
        .x2          (x2),
        .y2          (y2),
        .z2          (z2),
        .line_count  (line_count),
        .drop_count  (drop_count),
        .busy        (busy),
        .done        (done)
    );

    // Strobe monitor: records each transfer and flags wide pulses or short gaps.
    int          cyc = 0;
    logic [47:0] strobe_seg [$];
    int          strobe_cyc [$];
    logic        prev_iv = 1'b0;
    int          last_cyc = -100;
    int          width_err = 0;
    int          gap_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_val) begin
            strobe_seg.push_back({x1, y1, z1, x2, y2, z2});
            strobe_cyc.push_back(cyc);
            if (prev_iv) width_err <= width_err + 1;
            if (cyc - last_cyc < 4) gap_err <= gap_err + 1;
            last_cyc <= cyc;
        end
        prev_iv <= in_val;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        pt_valid    = 1'b0;
        pt_new_path = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_pt(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                           input logic np);
        int w;
        w           = 0;
        pt_valid    = 1'b1;
        pt_x        = x;
        pt_y        = y;
        pt_z        = z;
        pt_new_path = np;
        while (!pt_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!pt_ready) check_val("send_ready_timeout", pt_ready, 1);
        @(negedge clk);
        pt_valid    = 1'b0;
        pt_new_path = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        repeat (2) @(negedge clk);
        while (busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_val("idle_timeout", busy, 0);
    endtask

    task automatic clear_log();
        strobe_seg.delete();
        strobe_cyc.delete();
    endtask

    initial begin
        int         w;
        logic [7:0] a;

        // Reset state
        do_reset();
        check_val("rst_in_val", in_val, 0);
        check_val("rst_seg", {x1, y1, z1, x2, y2, z2}, 0);
        check_val("rst_line_count", line_count, 0);
        check_val("rst_drop_count", drop_count, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_pt_ready", pt_ready, 1);

        // Two segments from three vertices, strobes 4 cycles apart
        clear_log();
        send_pt(8'd0, 8'd0, 8'd0, 1'b0);
        send_pt(8'd10, 8'd0, 8'd0, 1'b0);
        send_pt(8'd10, 8'd10, 8'd0, 1'b0);
        wait_idle();
        check_val("t1_strobes", strobe_seg.size(), 2);
        if (strobe_seg.size() >= 2) begin
            check_val("t1_seg0", strobe_seg[0], 48'h00_00_00_0A_00_00);
            check_val("t1_seg1", strobe_seg[1], 48'h0A_00_00_0A_0A_00);
            check_val("t1_spacing", strobe_cyc[1] - strobe_cyc[0], 4);
        end
        check_val("t1_line_count", line_count, 2);

        // Zero-length segment is dropped
        clear_log();
        send_pt(8'd5, 8'd5, 8'd5, 1'b1);
        send_pt(8'd5, 8'd5, 8'd5, 1'b0);
        send_pt(8'd9, 8'd5, 8'd5, 1'b0);
        wait_idle();
        check_val("t2_strobes", strobe_seg.size(), 1);
        if (strobe_seg.size() >= 1) check_val("t2_seg0", strobe_seg[0], 48'h05_05_05_09_05_05);
        check_val("t2_drop_count", drop_count, 1);
        check_val("t2_line_count", line_count, 3);

        // New-path marker breaks the chain
        clear_log();
        send_pt(8'd1, 8'd1, 8'd1, 1'b1);
        send_pt(8'd2, 8'd2, 8'd2, 1'b0);
        send_pt(8'd7, 8'd7, 8'd7, 1'b1);
        send_pt(8'd8, 8'd8, 8'd8, 1'b0);
        wait_idle();
        check_val("t3_strobes", strobe_seg.size(), 2);
        if (strobe_seg.size() >= 2) begin
            check_val("t3_seg0", strobe_seg[0], 48'h01_01_01_02_02_02);
            check_val("t3_seg1", strobe_seg[1], 48'h07_07_07_08_08_08);
        end
        check_val("t3_line_count", line_count, 5);
        check_val("t3_drop_count", drop_count, 1);

        // Burst of 12 collinear vertices: FIFO fills to 8, then 10 segments sent, then done
        do_reset();
        clear_log();
        for (int i = 0; i < 12; i++) begin
            a = 8'(i);
            send_pt(a, 8'(2 * i), 8'(3 * i), 1'b0);
        end
        check_val("t4_full_ready", pt_ready, 0);
        check_val("t4_busy", busy, 1);
        w = 0;
        while (!(in_val && line_count == 8'd9) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check_val("t5_last_strobe", in_val, 1);
        check_val("t5_done_before", done, 0);
        @(negedge clk);
        check_val("t5_done", done, 1);
        check_val("t5_ready_low", pt_ready, 0);
        check_val("t5_line_count", line_count, 10);
        repeat (20) @(negedge clk);
        check_val("t5_strobes", strobe_seg.size(), 10);
        for (int k = 0; k < 10 && k < strobe_seg.size(); k++) begin
            check_val($sformatf("t5_seg%0d", k), strobe_seg[k],
                      {8'(k), 8'(2 * k), 8'(3 * k), 8'(k + 1), 8'(2 * k + 2), 8'(3 * k + 3)});
        end
        check_val("t5_busy_retained", busy, 1);
        check_val("t5_done_sticky", done, 1);

        // Reset during STROBE
        do_reset();
        clear_log();
        send_pt(8'd1, 8'd2, 8'd3, 1'b0);
        send_pt(8'd4, 8'd5, 8'd6, 1'b0);
        w = 0;
        while (!in_val && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_val("t6_strobe_seen", in_val, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("t6_in_val", in_val, 0);
        check_val("t6_line_count", line_count, 0);
        check_val("t6_drop_count", drop_count, 0);
        check_val("t6_busy", busy, 0);
        check_val("t6_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        clear_log();
        send_pt(8'd20, 8'd20, 8'd20, 1'b0);
        repeat (6) @(negedge clk);
        check_val("t6_no_prev_strobes", strobe_seg.size(), 0);
        check_val("t6_no_prev_busy", busy, 0);
        send_pt(8'd30, 8'd30, 8'd30, 1'b0);
        wait_idle();
        check_val("t6_strobes", strobe_seg.size(), 1);
        if (strobe_seg.size() >= 1) check_val("t6_seg0", strobe_seg[0], 48'h14_14_14_1E_1E_1E);
        check_val("t6_line_count_after", line_count, 1);

        // Strobe shape over the whole run
        check_val("pulse_width", width_err, 0);
        check_val("strobe_gap", gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
